// File: rtl/set_host.sv
// ----------------------------------------------------------------------------
// set_host
//
// Self-test initiator for a SET lattice-point-counting core. For each pattern
// it reads circle parameters and the expected count from a synchronous ROM,
// waits for the core to go idle, issues a one-cycle `en` request, collects
// `candidate` on `valid` and compares it with the expected count. A run ends
// after NUM_PAT patterns, after MAX_ERR mismatches, or when one pattern waits
// TIMEOUT cycles for its result.
//
// Parameters
//   NUM_PAT   patterns per run (1..64)
//   MAX_ERR   mismatch count that aborts the run
//   TIMEOUT   cycles allowed from `en` to `valid`
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset
//   start        one-cycle run request, accepted in IDLE or DONE
//   mode_cfg     SET mode for the run, latched on accepted start
//   pat_addr     ROM address (current pattern index)
//   pat_central  ROM circle centre, valid one cycle after pat_addr
//   pat_radius   ROM circle radius, same timing
//   pat_expected ROM expected candidate count, same timing
//   en           SET request, one cycle per pattern
//   central      SET centre, held from ISSUE until the next ISSUE
//   radius       SET radius, held like central
//   mode         SET mode (latched mode_cfg)
//   busy         SET busy
//   valid        SET result strobe
//   candidate    SET result
//   done         run finished; held until the next accepted start
//   pass         with done: no mismatches and no timeout
//   err_cnt      mismatches this run, saturating at 127
//   fail_idx     index of the first mismatch or timeout, 0 if none
//   timeout      sticky; a pattern ran out of time
// ----------------------------------------------------------------------------
module set_host #(
    parameter int NUM_PAT = 64,
    parameter int MAX_ERR = 10,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode_cfg,
    output logic [5:0]  pat_addr,
    input  logic [23:0] pat_central,
    input  logic [11:0] pat_radius,
    input  logic [7:0]  pat_expected,
    output logic        en,
    output logic [23:0] central,
    output logic [11:0] radius,
    output logic [1:0]  mode,
    input  logic        busy,
    input  logic        valid,
    input  logic [7:0]  candidate,
    output logic        done,
    output logic        pass,
    output logic [6:0]  err_cnt,
    output logic [5:0]  fail_idx,
    output logic        timeout
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH      = 3'd1;
    localparam logic [2:0] S_WAIT_IDLE  = 3'd2;
    localparam logic [2:0] S_ISSUE      = 3'd3;
    localparam logic [2:0] S_WAIT_VALID = 3'd4;
    localparam logic [2:0] S_CHECK      = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    localparam int              TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
    localparam logic [5:0]      LAST_IDX  = 6'(NUM_PAT - 1);
    localparam logic [6:0]      MAX_ERR_C = 7'(MAX_ERR);
    localparam logic [6:0]      ERR_SAT   = 7'h7f;

    logic [2:0]       state_q,    state_d;
    logic [5:0]       idx_q,      idx_d;
    logic [TMO_W-1:0] tmo_cnt_q,  tmo_cnt_d;
    logic [7:0]       exp_q,      exp_d;
    logic [7:0]       res_q,      res_d;
    logic [23:0]      central_q,  central_d;
    logic [11:0]      radius_q,   radius_d;
    logic [1:0]       mode_q,     mode_d;
    logic             en_q,       en_d;
    logic             done_q,     done_d;
    logic             pass_q,     pass_d;
    logic [6:0]       err_cnt_q,  err_cnt_d;
    logic [5:0]       fail_idx_q, fail_idx_d;
    logic             timeout_q,  timeout_d;
    // Set once fail_idx holds the first failing pattern of the run.
    logic             failed_q,   failed_d;

    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned;
        // a missing default here would infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        tmo_cnt_d  = tmo_cnt_q;
        exp_d      = exp_q;
        res_d      = res_q;
        central_d  = central_q;
        radius_d   = radius_q;
        mode_d     = mode_q;
        en_d       = 1'b0;
        done_d     = done_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        fail_idx_d = fail_idx_q;
        timeout_d  = timeout_q;
        failed_d   = failed_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_cnt_d  = '0;
                    timeout_d  = 1'b0;
                    fail_idx_d = '0;
                    failed_d   = 1'b0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    idx_d      = '0;
                    mode_d     = mode_cfg;
                    state_d    = S_FETCH;
                end
            end

            // pat_addr already carries idx; the ROM answers next cycle.
            S_FETCH: begin
                state_d = S_WAIT_IDLE;
            end

            // pat_addr is held throughout, so ROM data stays valid however
            // long busy lasts; it is registered on the way into ISSUE so
            // central/radius never change before the request that uses them.
            S_WAIT_IDLE: begin
                if (!busy) begin
                    central_d = pat_central;
                    radius_d  = pat_radius;
                    exp_d     = pat_expected;
                    en_d      = 1'b1;
                    state_d   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT_VALID;
            end

            // valid takes priority, so a result arriving in the expiry
            // cycle is still accepted.
            S_WAIT_VALID: begin
                if (valid) begin
                    res_d   = candidate;
                    state_d = S_CHECK;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (tmo_cnt_d == TMO_LIMIT) begin
                        timeout_d = 1'b1;
                        if (!failed_q) begin
                            fail_idx_d = idx_q;
                        end
                        failed_d = 1'b1;
                        done_d   = 1'b1;
                        pass_d   = 1'b0;
                        state_d  = S_DONE;
                    end
                end
            end

            // The abort test uses the updated error count, so the run stops
            // on the pattern that produced the MAX_ERR-th mismatch.
            S_CHECK: begin
                if (res_q != exp_q) begin
                    if (err_cnt_q != ERR_SAT) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (!failed_q) begin
                        fail_idx_d = idx_q;
                    end
                    failed_d = 1'b1;
                end
                if (err_cnt_d == MAX_ERR_C || idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0) && !timeout_q;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tmo_cnt_q  <= '0;
            exp_q      <= '0;
            res_q      <= '0;
            central_q  <= '0;
            radius_q   <= '0;
            mode_q     <= '0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_idx_q <= '0;
            timeout_q  <= 1'b0;
            failed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tmo_cnt_q  <= tmo_cnt_d;
            exp_q      <= exp_d;
            res_q      <= res_d;
            central_q  <= central_d;
            radius_q   <= radius_d;
            mode_q     <= mode_d;
            en_q       <= en_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            fail_idx_q <= fail_idx_d;
            timeout_q  <= timeout_d;
            failed_q   <= failed_d;
        end
    end

    assign pat_addr = idx_q;
    assign en       = en_q;
    assign central  = central_q;
    assign radius   = radius_q;
    assign mode     = mode_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign fail_idx = fail_idx_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_set_host.sv
// ----------------------------------------------------------------------------
// tb_set_host
//
// Directed bench for set_host with its default parameters. A synchronous ROM
// model serves hand-defined patterns; a SET model answers each `en` after a
// per-pattern delay with either the expected count or a corrupted one, and
// checks the request data it receives. Run-level results are checked against
// hand-computed values.
// ----------------------------------------------------------------------------
module tb_set_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode_cfg;
    logic [5:0]  pat_addr;
    logic [23:0] pat_central;
    logic [11:0] pat_radius;
    logic [7:0]  pat_expected;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic        busy;
    logic        valid;
    logic [7:0]  candidate;
    logic        done;
    logic        pass;
    logic [6:0]  err_cnt;
    logic [5:0]  fail_idx;
    logic        timeout;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    set_host dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode_cfg     (mode_cfg),
        .pat_addr     (pat_addr),
        .pat_central  (pat_central),
        .pat_radius   (pat_radius),
        .pat_expected (pat_expected),
        .en           (en),
        .central      (central),
        .radius       (radius),
        .mode         (mode),
        .busy         (busy),
        .valid        (valid),
        .candidate    (candidate),
        .done         (done),
        .pass         (pass),
        .err_cnt      (err_cnt),
        .fail_idx     (fail_idx),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    wire all_out_zero = ~|{en, central, radius, mode, pat_addr, done, pass,
                           err_cnt, fail_idx, timeout};

    // Pattern contents.
    function automatic logic [23:0] rom_c(input int i);
        return {8'h5a, 8'(i), 8'(i * 7)};
    endfunction
    function automatic logic [11:0] rom_r(input int i);
        return 12'(i * 13 + 1);
    endfunction
    function automatic logic [7:0] rom_e(input int i);
        return 8'(i * 11 + 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Synchronous ROM: data follows the address by one clock.
    logic [5:0] rom_a;
    always @(posedge clk) begin
        rom_a = pat_addr;
        #1;
        pat_central  = rom_c(int'(rom_a));
        pat_radius   = rom_r(int'(rom_a));
        pat_expected = rom_e(int'(rom_a));
    end

    // SET model and request monitor, evaluated mid-cycle.
    int          en_cnt;
    int          bad_issue;
    int          cd;
    int          never_idx;
    int          late_idx;
    int          en_cyc;
    int          tmo_cyc;
    bit          tmo_seen;
    bit          all_wrong;
    bit          seen;
    logic        prev_en;
    logic [1:0]  run_mode;
    logic [63:0] wrong_mask;
    logic [7:0]  pend_cand;
    logic [23:0] last_c;
    logic [11:0] last_r;

    always @(negedge clk) begin
        if (!rst) begin
            cd      = 0;
            valid   = 1'b0;
            prev_en = 1'b0;
            seen    = 1'b0;
        end else begin
            valid = 1'b0;
            if (cd != 0) begin
                cd--;
                if (cd == 0) begin
                    valid     = 1'b1;
                    candidate = pend_cand;
                end
            end
            if (en) begin
                if (prev_en) bad_issue++;
                if (central != rom_c(en_cnt) || radius != rom_r(en_cnt) || mode != run_mode)
                    bad_issue++;
                pend_cand = (all_wrong || wrong_mask[en_cnt[5:0]]) ? ~rom_e(en_cnt) : rom_e(en_cnt);
                if (en_cnt == never_idx) begin
                    cd     = 0;
                    en_cyc = cyc;
                end else if (en_cnt == late_idx) begin
                    cd = 1024;
                end else begin
                    cd = 5;
                end
                last_c = central;
                last_r = radius;
                seen   = 1'b1;
                en_cnt++;
            end else if (seen && (central != last_c || radius != last_r)) begin
                bad_issue++;
            end
            if (timeout && !tmo_seen) begin
                tmo_seen = 1'b1;
                tmo_cyc  = cyc;
            end
            prev_en = en;
        end
    end

    task automatic begin_run(input logic [1:0] m);
        en_cnt    = 0;
        bad_issue = 0;
        run_mode  = m;
        mode_cfg  = m;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_en(input int target, input int budget);
        int n = 0;
        while (en_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_en_reached", 32'(en_cnt >= target), 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        busy       = 1'b0;
        mode_cfg   = 2'b00;
        valid      = 1'b0;
        candidate  = 8'h00;
        en_cnt     = 0;
        bad_issue  = 0;
        cd         = 0;
        never_idx  = -1;
        late_idx   = -1;
        en_cyc     = 0;
        tmo_cyc    = 0;
        tmo_seen   = 1'b0;
        all_wrong  = 1'b0;
        seen       = 1'b0;
        prev_en    = 1'b0;
        run_mode   = 2'b00;
        wrong_mask = '0;
        pend_cand  = 8'h00;
        last_c     = '0;
        last_r     = '0;

        #2;
        check("reset_outputs_zero", 32'(all_out_zero), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_en", en_cnt, 0);

        // Clean run: every pattern answered correctly after 5 cycles.
        begin_run(2'b01);
        wait_done("clean_done", 3000);
        check("clean_en_count", en_cnt, 64);
        check("clean_pass", 32'(pass), 32'd1);
        check("clean_err_cnt", 32'(err_cnt), 32'd0);
        check("clean_fail_idx", 32'(fail_idx), 32'd0);
        check("clean_timeout", 32'(timeout), 32'd0);
        check("clean_issue_data", bad_issue, 0);
        check("clean_mode", 32'(mode), 32'd1);

        // Patterns 3 and 7 answered wrongly.
        wrong_mask = (64'd1 << 3) | (64'd1 << 7);
        begin_run(2'b10);
        wait_done("two_err_done", 3000);
        check("two_err_en_count", en_cnt, 64);
        check("two_err_err_cnt", 32'(err_cnt), 32'd2);
        check("two_err_fail_idx", 32'(fail_idx), 32'd3);
        check("two_err_pass", 32'(pass), 32'd0);
        check("two_err_issue_data", bad_issue, 0);
        wrong_mask = '0;

        // Every answer wrong: abort after the tenth mismatch (pattern 9).
        all_wrong = 1'b1;
        begin_run(2'b00);
        wait_done("abort_done", 3000);
        check("abort_en_count", en_cnt, 10);
        check("abort_err_cnt", 32'(err_cnt), 32'd10);
        check("abort_fail_idx", 32'(fail_idx), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        all_wrong = 1'b0;

        // Pattern 2 answers in the expiry cycle (en+1024, must be accepted);
        // pattern 5 never answers. The flag is registered at the end of the
        // expiry cycle en+1024, so it is first seen in cycle en+1025.
        late_idx  = 2;
        never_idx = 5;
        tmo_seen  = 1'b0;
        begin_run(2'b01);
        wait_done("timeout_done", 5000);
        check("timeout_flag", 32'(timeout), 32'd1);
        check("timeout_fail_idx", 32'(fail_idx), 32'd5);
        check("timeout_en_count", en_cnt, 6);
        check("timeout_err_cnt", 32'(err_cnt), 32'd0);
        check("timeout_pass", 32'(pass), 32'd0);
        check("timeout_latency", tmo_cyc - en_cyc, 1025);
        late_idx  = -1;
        never_idx = -1;

        // busy held before pattern 0, then a mid-run start that must be ignored.
        busy = 1'b1;
        begin_run(2'b10);
        repeat (49) @(negedge clk);
        #1;
        check("busy_hold_no_en", en_cnt, 0);
        busy = 1'b0;
        @(negedge clk);
        #1;
        check("en_after_busy", en_cnt, 1);
        wait_en(20, 500);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_done", 3000);
        check("busy_en_count", en_cnt, 64);
        check("busy_pass", 32'(pass), 32'd1);
        check("busy_issue_data", bad_issue, 0);

        // Reset while waiting for a result, then restart with mode 3.
        begin_run(2'b01);
        wait_en(3, 200);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrun_reset_zero", 32'(all_out_zero), 32'd1);
        repeat (2) @(negedge clk);
        #1;
        rst    = 1'b1;
        en_cnt = 0;
        repeat (20) @(negedge clk);
        #1;
        check("no_en_after_reset", en_cnt, 0);
        begin_run(2'b11);
        wait_done("restart_done", 3000);
        check("restart_mode", 32'(mode), 32'd3);
        check("restart_en_count", en_cnt, 64);
        check("restart_pass", 32'(pass), 32'd1);
        check("restart_issue_data", bad_issue, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
